// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode definitions for the cpu_core slice.
//   - RV32I opcode and funct3/funct7 constants for the supported subset
//   - alu_op_e:        ALU operation selector
//   - decoded_instr_t: fields produced by decode() for the EX stage
//   - decode():        maps an instruction word to decoded_instr_t
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        use_rs1;
    logic        use_rs2;
    logic        we;
    logic        illegal;
  } decoded_instr_t;

  // funct3 -> operation, assuming the base (funct7 = 0) variant.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decoded_instr_t decode(input logic [31:0] instr);
    decoded_instr_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7        = instr[31:25];
    f3        = instr[14:12];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.rd      = instr[11:7];
    d.imm     = {{20{instr[31]}}, instr[31:20]};
    d.alu_op  = ALU_ADD;
    d.use_rs1 = 1'b0;
    d.use_rs2 = 1'b0;
    d.we      = 1'b0;
    d.illegal = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        // LUI is computed as 0 + imm: rs1 is not used, so operand a is zero.
        d.imm = {instr[31:12], 12'h000};
        d.we  = 1'b1;
      end
      OPC_OP_IMM: begin
        d.use_rs1 = 1'b1;
        d.we      = 1'b1;
        d.alu_op  = base_op(f3);
        // Only the shift immediates constrain the upper immediate bits.
        if (f3 == F3_SLL && f7 != F7_BASE) d.illegal = 1'b1;
        if (f3 == F3_SRL_SRA) begin
          if (f7 == F7_ALT)        d.alu_op  = ALU_SRA;
          else if (f7 != F7_BASE)  d.illegal = 1'b1;
        end
      end
      OPC_OP: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.we      = 1'b1;
        d.alu_op  = base_op(f3);
        if (f7 == F7_ALT && f3 == F3_ADD_SUB)      d.alu_op  = ALU_SUB;
        else if (f7 == F7_ALT && f3 == F3_SRL_SRA) d.alu_op  = ALU_SRA;
        else if (f7 != F7_BASE)                    d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // An illegal instruction is a NOP: it reads nothing, so it can never
    // stall or bypass, and it writes nothing.
    if (d.illegal) begin
      d.use_rs1 = 1'b0;
      d.use_rs2 = 1'b0;
      d.we      = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational RV32I integer ALU.
//   i_a      operand a (rs1 value, or zero for LUI)
//   i_b      operand b (rs2 value or sign-extended immediate)
//   i_alu_op operation select
//   o_result result; shift amount is i_b[4:0], add/sub wrap
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_e         i_alu_op,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_shamt = i_b[4:0];
  assign w_lt_s  = $signed(i_a) < $signed(i_b);
  assign w_lt_u  = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: three-stage in-order RV32I integer execute core (IF latch, EX, WB)
// for the OP / OP-IMM / LUI subset, with a 32x32 register file (x0 = 0).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr_valid       encoded_value holds an instruction
//   encoded_value     RV32I instruction word
//   in_ready          core accepts encoded_value this cycle
//   curr_rd           destination of an externally pending write (0 = none)
//   we_stall          EX held this cycle
//   we_bypass         an EX operand is forwarded from WB this cycle
//   wb_valid          register-file write at this edge (also for rd = x0)
//   wb_rd, wb_data    write destination and data
//   illegal           sticky unsupported-instruction flag
//   dbg_addr/dbg_data combinational register-file read port
//
// Build option: CPU_BYPASS_EN. When defined, a WB-to-EX dependency is
// forwarded. When undefined, the dependency stalls EX for one cycle and
// we_bypass is tied low.
//
// Handshake: an instruction transfers at a rising edge where
// instr_valid && in_ready. in_ready drops only while a valid EX
// instruction is stalled; an instruction offered while in_ready is low is
// not taken.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     encoded_value,
  output logic            in_ready,
  input  logic [4:0]      curr_rd,
  output logic            we_stall,
  output logic            we_bypass,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_ex_valid;
  logic [31:0]     r_ex_instr;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;

  decoded_instr_t  w_dec;
  logic [XLEN-1:0] w_rs1_rf;
  logic [XLEN-1:0] w_rs2_rf;
  logic            w_ext1;
  logic            w_ext2;
  logic            w_hit1;
  logic            w_hit2;
  logic            w_ext_stall;
  logic            w_stall;
  logic            w_bypass;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_result;

  assign w_dec    = decode(r_ex_instr);
  assign w_rs1_rf = (w_dec.rs1 == 5'd0) ? '0 : r_regs[w_dec.rs1];
  assign w_rs2_rf = (w_dec.rs2 == 5'd0) ? '0 : r_regs[w_dec.rs2];

  // Only sources the instruction really reads take part in hazards.
  assign w_ext1 = r_ex_valid && w_dec.use_rs1 && curr_rd != 5'd0 && curr_rd == w_dec.rs1;
  assign w_ext2 = r_ex_valid && w_dec.use_rs2 && curr_rd != 5'd0 && curr_rd == w_dec.rs2;
  assign w_hit1 = r_ex_valid && w_dec.use_rs1 && r_wb_valid && r_wb_rd != 5'd0
                  && r_wb_rd == w_dec.rs1;
  assign w_hit2 = r_ex_valid && w_dec.use_rs2 && r_wb_valid && r_wb_rd != 5'd0
                  && r_wb_rd == w_dec.rs2;
  assign w_ext_stall = w_ext1 || w_ext2;

`ifdef CPU_BYPASS_EN
  // An external hazard outranks forwarding: nothing is forwarded while held.
  assign w_stall  = w_ext_stall;
  assign w_bypass = !w_ext_stall && (w_hit1 || w_hit2);
  assign w_op1    = w_hit1 ? r_wb_data : w_rs1_rf;
  assign w_op2    = w_hit2 ? r_wb_data : w_rs2_rf;
`else
  // WB writes at the end of this cycle; holding EX one cycle lets the
  // register file supply the new value.
  assign w_stall  = w_ext_stall || w_hit1 || w_hit2;
  assign w_bypass = 1'b0;
  assign w_op1    = w_rs1_rf;
  assign w_op2    = w_rs2_rf;
`endif

  assign w_a = w_dec.use_rs1 ? w_op1 : '0;
  assign w_b = w_dec.use_rs2 ? w_op2 : XLEN'(w_dec.imm);

  cpu_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_alu_op (w_dec.alu_op),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_instr <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (r_ex_valid && w_dec.illegal) r_illegal <= 1'b1;
      if (w_stall) begin
        // EX holds its instruction; WB receives a bubble.
        r_wb_valid <= 1'b0;
      end else begin
        r_wb_valid <= r_ex_valid && w_dec.we;
        r_wb_rd    <= w_dec.rd;
        r_wb_data  <= w_result;
        r_ex_valid <= instr_valid;
        if (instr_valid) r_ex_instr <= encoded_value;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_wb_valid && r_wb_rd != 5'd0) begin
      r_regs[r_wb_rd] <= r_wb_data;
    end
  end

  assign in_ready  = !w_stall;
  assign we_stall  = w_stall;
  assign we_bypass = w_bypass;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign illegal   = r_illegal;
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] encoded_value = '0;
  logic        in_ready;
  logic [4:0]  curr_rd = '0;
  logic        we_stall;
  logic        we_bypass;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  cpu_core dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .encoded_value (encoded_value),
    .in_ready      (in_ready),
    .curr_rd       (curr_rd),
    .we_stall      (we_stall),
    .we_bypass     (we_bypass),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .illegal       (illegal),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] ref_regs [32];   // architectural state in program order
  logic        m_ex_v, m_legal, m_u1, m_u2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_res;
  logic        m_wb_v;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  logic        m_ill;
  int          seen_stall, seen_byp, seen_x0_wb;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    m_ex_v = 0; m_wb_v = 0; m_ill = 0;
    m_legal = 0; m_u1 = 0; m_u2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_res = 0;
    m_wb_rd = 0; m_wb_data = 0;
  endtask

  // Executes one instruction architecturally, straight from the ISA rules.
  task automatic ref_exec(input logic [31:0] ins);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, imm, r;
    logic        ok, alt;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
    imm = {{20{ins[31]}}, ins[31:20]};
    a = ref_regs[m_rs1];
    b = (op == 7'h33) ? ref_regs[m_rs2] : imm;
    alt = (f7 == 7'h20);
    ok = 1; r = 0; m_u1 = 0; m_u2 = 0;
    if (op == 7'h37) begin
      r = {ins[31:12], 12'h000};
    end else if (op == 7'h13 || op == 7'h33) begin
      m_u1 = 1; m_u2 = (op == 7'h33);
      if (op == 7'h33)  ok = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
      else if (f3 == 1) ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0) || alt;
      case (f3)
        3'd0: r = (op == 7'h33 && alt) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else begin
      ok = 0;
    end
    if (!ok) begin m_u1 = 0; m_u2 = 0; end
    m_legal = ok;
    m_res = r;
    if (ok && m_rd != 0) ref_regs[m_rd] = r;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs, checks the cycle's outputs against the
  // transaction model, then advances the model across the coming edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [4:0] crd,
                      output logic acc);
    logic ex_stall, wb_hit, e_stall, e_byp;
    @(negedge clk);
    instr_valid = v; encoded_value = ins; curr_rd = crd;
    #1;
    ex_stall = m_ex_v && crd != 0 && ((m_u1 && crd == m_rs1) || (m_u2 && crd == m_rs2));
    wb_hit = m_ex_v && m_wb_v && m_wb_rd != 0 &&
             ((m_u1 && m_rs1 == m_wb_rd) || (m_u2 && m_rs2 == m_wb_rd));
`ifdef CPU_BYPASS_EN
    e_stall = ex_stall;
    e_byp   = !ex_stall && wb_hit;
`else
    e_stall = ex_stall || wb_hit;
    e_byp   = 1'b0;
`endif
    chk("we_stall", 32'(we_stall), 32'(e_stall));
    chk("we_bypass", 32'(we_bypass), 32'(e_byp));
    chk("in_ready", 32'(in_ready), 32'(!e_stall));
    chk("wb_valid", 32'(wb_valid), 32'(m_wb_v));
    chk("illegal", 32'(illegal), 32'(m_ill));
    if (m_wb_v) begin
      exp_q.push_back({27'd0, m_wb_rd});
      exp_q.push_back(m_wb_data);
    end
    if (wb_valid && exp_q.size() >= 2) begin
      chk("wb_rd", 32'(wb_rd), exp_q.pop_front());
      chk("wb_data", wb_data, exp_q.pop_front());
    end
    exp_q.delete();
    if (we_stall) seen_stall++;
    if (we_bypass) seen_byp++;
    if (wb_valid && wb_rd == 0) seen_x0_wb++;
    if (m_ex_v && !m_legal) m_ill = 1;
    acc = v && !e_stall;
    if (e_stall) begin
      m_wb_v = 0;
    end else begin
      m_wb_v = m_ex_v && m_legal;
      m_wb_rd = m_rd;
      m_wb_data = m_res;
      m_ex_v = v;
      if (v) ref_exec(ins);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    logic acc;
    step(1'b1, ins, 5'd0, acc);
  endtask

  task automatic idle(input int n, input logic [4:0] crd);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, crd, acc);
  endtask

  task automatic read_reg(input int idx, output logic [31:0] val);
    dbg_addr = 5'(idx);
    #1;
    val = dbg_data;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      chk($sformatf("%s_x%0d", tag, i), v, ref_regs[i]);
    end
  endtask

  task automatic check_reg_const(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] v;
    read_reg(idx, v);
    chk(tag, v, exp);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [31:0] rnd;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    rnd = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      4, 5, 6: begin
        if (f3 == 1) imm[11:5] = 7'h00;
        if (f3 == 5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'h13};
      end
      7: return {rnd[19:0], rd, 7'h37};
      8: return {7'h01, rs2, rs1, f3, rd, 7'h33};
      default: return rnd;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic acc;
    logic [31:0] pend;
    logic        have;
    logic        v;
    logic [4:0]  crd;

    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we_stall", 32'(we_stall), 32'd0);
    chk("rst_we_bypass", 32'(we_bypass), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    check_regs("rst");

    // back-to-back dependents
    seen_stall = 0; seen_byp = 0;
    issue(32'h00500093);
    issue(32'h00708113);
    idle(4, 5'd0);
    check_reg_const("x1_addi", 1, 32'd5);
    check_reg_const("x2_dep", 2, 32'd12);
`ifdef CPU_BYPASS_EN
    chk("dep_bypass_cycles", 32'(seen_byp), 32'd1);
    chk("dep_stall_cycles", 32'(seen_stall), 32'd0);
`else
    chk("dep_bypass_cycles", 32'(seen_byp), 32'd0);
    chk("dep_stall_cycles", 32'(seen_stall), 32'd1);
`endif

    // double dependency and SUB
    issue(32'h002081B3);
    issue(32'h40100233);
    idle(4, 5'd0);
    check_reg_const("x3_add", 3, 32'd17);
    check_reg_const("x4_sub", 4, 32'hFFFFFFFB);

    // external stall
    issue(32'h123452B7);
    idle(4, 5'd0);
    check_reg_const("x5_lui", 5, 32'h12345000);
    seen_stall = 0;
    issue(32'h00528333);
    idle(3, 5'd5);
    chk("ext_stall_cycles", 32'(seen_stall), 32'd3);
    idle(4, 5'd0);
    chk("ext_stall_total", 32'(seen_stall), 32'd3);
    check_reg_const("x6_add", 6, 32'h2468A000);

    // write to x0
    seen_x0_wb = 0;
    issue(32'h00900013);
    idle(4, 5'd0);
    chk("x0_wb_seen", 32'(seen_x0_wb), 32'd1);
    check_reg_const("x0_zero", 0, 32'd0);

    // illegal instruction
    issue(32'hFFFFFFFF);
    idle(4, 5'd0);
    chk("illegal_set", 32'(illegal), 32'd1);
    check_regs("after_illegal");
    issue(32'h00500093);
    idle(4, 5'd0);
    chk("illegal_sticky", 32'(illegal), 32'd1);

    // randomized stream with random gaps and external hazards
    have = 0; pend = '0;
    for (int n = 0; n < 400; n++) begin
      if (!have) begin
        pend = gen_instr();
        have = ($urandom_range(0, 3) != 0);
      end
      v = have;
      crd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
      step(v, pend, crd, acc);
      if (acc) have = 0;
    end
    idle(5, 5'd0);
    check_regs("random");

    // reset with two instructions in flight
    issue(32'h00100393);
    issue(32'h00338413);
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr_valid = 1'b0;
    curr_rd = 5'd0;
    model_clear();
    #1;
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4, 5'd0);
    check_regs("midrst");
    check_reg_const("midrst_x7", 7, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
